adc_buffer_reader: RTL and testbench
====================================

Name: adc_buffer_reader

Overview:
- Read-side engine for the 2048-byte ADC capture buffer (the dual-port block RAM, port B).
- Once the capture side has frozen the buffer, it reads the samples around the stored trigger address and reduces them to one min/max pair per display column.
- It writes each pair into the VGA column store, then raises VGA_WRITE_DONE so the capture state machine can re-arm.
- Sits between the ADC buffer and the VGA waveform renderer.

Parameters:
- P_COLUMNS, 640, number of display columns produced per frame.
- P_ADDR_W, 11, RAM address width (2048 entries, circular).
- P_DATA_W, 8, sample width.

Ports:
- CLK_64MHZ  in  1  system clock; RAM port B is clocked from the same clock.
- MASTER_RST  in  1  reset; synchronous, active-high.
- BUF_READY  in  1  level; high while the capture side holds the buffer frozen (write_buffer state).
- TRIG_ADDR  in  11  buffer address of the trigger sample; stable while BUF_READY is high.
- PRETRIG  in  10  number of samples to display before the trigger.
- DECIMATE  in  2  samples per column, 1..3; 0 is treated as 1.
- RAM_ADDR  out  11  RAM port B read address.
- RAM_DATA  in  8  RAM port B data; valid one clock after RAM_ADDR.
- COL_ADDR  out  10  column index, 0..P_COLUMNS-1.
- COL_MIN  out  8  minimum sample in the column.
- COL_MAX  out  8  maximum sample in the column.
- COL_WE  out  1  one-cycle write strobe for COL_ADDR/COL_MIN/COL_MAX.
- VGA_WRITE_DONE  out  1  frame-complete flag; level.

Behaviour:
- Reset (sync, high): state IDLE; RAM_ADDR=0, COL_ADDR=0, COL_MIN=0, COL_MAX=0, COL_WE=0, VGA_WRITE_DONE=0, all counters 0. Reset mid-frame aborts the frame immediately; no further COL_WE.
- States:
  - IDLE: wait for BUF_READY=1.
  - READ: issue addresses and reduce samples.
  - FLUSH: drain the 2-cycle data/write pipeline.
  - DONE: hold the frame-complete flag.
  - Any unused encoding goes to IDLE.
- IDLE→READ when BUF_READY=1 (sampled in cycle 0).
  - Latch D = (DECIMATE==0 ? 1 : DECIMATE).
  - Load start address = (TRIG_ADDR - PRETRIG) mod 2048, zero-extending PRETRIG.
- READ:
  - RAM_ADDR = start+i, i=0..N-1, presented in cycle 1+i, with N = P_COLUMNS*D (max 1920 < 2048, so no sample is read twice).
  - Address arithmetic is 11-bit, wrapping 0x7FF→0x000.
- Data pipeline:
  - Sample i arrives on RAM_DATA in cycle 2+i.
  - The first sample of each column loads min=max=sample; later samples update with unsigned compare. Equal values leave min/max unchanged.
  - On the D-th sample of a column, the next cycle drives COL_WE=1 with the finished pair on COL_MIN/COL_MAX and COL_ADDR=column index.
  - Column index increments after each write. The reduction keeps running without stalls, so consecutive column writes are D cycles apart.
- After the last address is issued → FLUSH. The last COL_WE (COL_ADDR=P_COLUMNS-1) occurs in cycle N+2.
- FLUSH→DONE: VGA_WRITE_DONE=1 from cycle N+3.
  - Held while BUF_READY=1.
  - Cleared in the cycle after BUF_READY is sampled 0; state returns to IDLE.
- BUF_READY falling during READ/FLUSH:
  - Abort to IDLE next cycle.
  - No further COL_WE after the abort cycle; VGA_WRITE_DONE stays 0.
- Inputs TRIG_ADDR, PRETRIG and DECIMATE are sampled only at IDLE→READ; later changes are ignored until the next frame.
- Exactly P_COLUMNS COL_WE pulses per completed frame. COL_WE is never high in IDLE or DONE.

Decomposition:
- Shared package (adc_pkg):
  - state encodings (IDLE/READ/FLUSH/DONE);
  - P_ADDR_W and P_DATA_W;
  - buffer depth 2048;
  - P_COLUMNS.
- One sub-module, col_minmax_reducer, holds the running min/max and the per-column sample counter. Its interface is sample, sample_valid and D in; pair and strobe out.
- Address generator, top-level state machine and column counter stay in adc_buffer_reader.

Test Plan:
1. Start-address wrap: RAM model returns addr[7:0]; TRIG_ADDR=0x010, PRETRIG=0x020, DECIMATE=1, BUF_READY rises in cycle 0 -> RAM_ADDR=0x7F0 in cycle 1, 0x000 in cycle 17, last address 0x26F in cycle 640; COL0 min=max=0xF0; 640 COL_WE pulses; VGA_WRITE_DONE=1 in cycle 643.
2. Decimation min/max: TRIG_ADDR=0x100, PRETRIG=0, DECIMATE=2, same RAM model -> col0 = (0x00, 0x01), col5 = (0x0A, 0x0B); COL_WE pulses spaced 2 cycles apart; VGA_WRITE_DONE=1 in cycle 1283.
3. DECIMATE=0 -> behaves exactly as DECIMATE=1 (scenario 1 timing). DECIMATE=3, constant data 0x80 -> every column reads (0x80, 0x80); N=1920.
4. Done handshake: hold BUF_READY=1 for 50 cycles after done -> VGA_WRITE_DONE stays high. Drop BUF_READY -> VGA_WRITE_DONE=0 the next cycle and state is IDLE. Re-raise BUF_READY -> new frame starts from a fresh start address.
5. Abort: drop BUF_READY at cycle 100 -> no COL_WE after cycle 101, VGA_WRITE_DONE never asserts, block returns to IDLE.
6. Reset mid-frame: assert MASTER_RST for one cycle at cycle 300 -> all outputs 0 the next cycle. With BUF_READY still high after reset release, the frame restarts with COL_ADDR=0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, FSM encoding and small helpers for the ADC buffer read side.
// Imported by adc_buffer_reader and col_minmax_reducer.
package adc_pkg;

  localparam int BUF_DEPTH = 2048;
  localparam int P_ADDR_W  = $clog2(BUF_DEPTH);
  localparam int P_DATA_W  = 8;
  localparam int P_COLUMNS = 640;
  localparam int COL_W     = 10;
  localparam int PRE_W     = 10;
  localparam int DEC_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Zero decimation would mean an empty column, so it is read as one sample per column.
  function automatic logic [DEC_W-1:0] dec_norm(input logic [DEC_W-1:0] d);
    return (d == '0) ? DEC_W'(1) : d;
  endfunction

  // Index of the final sample of a frame: P_COLUMNS*D - 1 (at most 1919, fits the address width).
  function automatic logic [P_ADDR_W-1:0] frame_last(input logic [DEC_W-1:0] d);
    return P_ADDR_W'(P_COLUMNS * int'(d) - 1);
  endfunction

endpackage

// File: rtl/col_minmax_reducer.sv
// Folds a stream of unsigned samples into one min/max pair per group of D samples.
// The finished pair and its write strobe are registered and appear the cycle after the D-th sample.
module col_minmax_reducer
  import adc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [P_DATA_W-1:0] sample_i,
  input  logic                sample_valid_i,
  input  logic [DEC_W-1:0]    dec_i,
  output logic [P_DATA_W-1:0] min_o,
  output logic [P_DATA_W-1:0] max_o,
  output logic                strobe_o
);

  logic [DEC_W-1:0]    cnt_q;
  logic [P_DATA_W-1:0] min_q, max_q;
  logic [P_DATA_W-1:0] min_d, max_d;
  logic                first, last;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == dec_i - DEC_W'(1));

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (first) begin
      min_d = sample_i;
      max_d = sample_i;
    end else begin
      if (sample_i < min_q) min_d = sample_i;
      if (sample_i > max_q) max_d = sample_i;
    end
  end

  // Stage p2: running extremes and the registered column pair
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      min_o    <= '0;
      max_o    <= '0;
      strobe_o <= 1'b0;
    end else begin
      strobe_o <= 1'b0;
      if (sample_valid_i) begin
        min_q <= min_d;
        max_q <= max_d;
        if (last) begin
          cnt_q    <= '0;
          min_o    <= min_d;
          max_o    <= max_d;
          strobe_o <= 1'b1;
        end else begin
          cnt_q <= cnt_q + DEC_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_buffer_reader.sv
// Reads the frozen ADC capture buffer around the trigger point and writes one
// min/max pair per display column into the VGA column store.
module adc_buffer_reader
  import adc_pkg::*;
(
  input  logic                CLK_64MHZ,
  input  logic                MASTER_RST,
  input  logic                BUF_READY,
  input  logic [P_ADDR_W-1:0] TRIG_ADDR,
  input  logic [PRE_W-1:0]    PRETRIG,
  input  logic [DEC_W-1:0]    DECIMATE,
  output logic [P_ADDR_W-1:0] RAM_ADDR,
  input  logic [P_DATA_W-1:0] RAM_DATA,
  output logic [COL_W-1:0]    COL_ADDR,
  output logic [P_DATA_W-1:0] COL_MIN,
  output logic [P_DATA_W-1:0] COL_MAX,
  output logic                COL_WE,
  output logic                VGA_WRITE_DONE
);

  state_t              state_q;
  logic [P_ADDR_W-1:0] addr_q;
  logic [P_ADDR_W-1:0] rd_cnt_q;
  logic [P_ADDR_W-1:0] last_q;
  logic [DEC_W-1:0]    dec_q;
  logic [COL_W-1:0]    col_q;
  logic                flush_q;
  logic                done_q;
  logic                vld_p0_q;
  logic                vld_p1_q;
  logic                abort;
  logic                red_rst;
  logic                col_we;

  // Losing the buffer mid-frame kills the read pipeline and any half-built column.
  assign abort   = ((state_q == ST_READ) || (state_q == ST_FLUSH)) && !BUF_READY;
  assign red_rst = MASTER_RST || (state_q == ST_IDLE) || abort;

  assign RAM_ADDR       = addr_q;
  assign COL_ADDR       = col_q;
  assign COL_WE         = col_we;
  assign VGA_WRITE_DONE = done_q;

  // Stage p0: address issue and frame control
  always_ff @(posedge CLK_64MHZ) begin
    if (MASTER_RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rd_cnt_q <= '0;
      last_q   <= '0;
      dec_q    <= DEC_W'(1);
      col_q    <= '0;
      flush_q  <= 1'b0;
      done_q   <= 1'b0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      // Stage p1: RAM read latency, valid follows the address by one clock
      vld_p1_q <= vld_p0_q && !abort;
      if (col_we) begin
        col_q <= (col_q == COL_W'(P_COLUMNS - 1)) ? '0 : col_q + COL_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (BUF_READY) begin
            state_q  <= ST_READ;
            dec_q    <= dec_norm(DECIMATE);
            last_q   <= frame_last(dec_norm(DECIMATE));
            addr_q   <= TRIG_ADDR - {1'b0, PRETRIG};
            rd_cnt_q <= '0;
            col_q    <= '0;
            flush_q  <= 1'b0;
            vld_p0_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (!BUF_READY) begin
            state_q  <= ST_IDLE;
            vld_p0_q <= 1'b0;
          end else if (rd_cnt_q == last_q) begin
            state_q  <= ST_FLUSH;
            vld_p0_q <= 1'b0;
            flush_q  <= 1'b0;
          end else begin
            addr_q   <= addr_q + P_ADDR_W'(1);
            rd_cnt_q <= rd_cnt_q + P_ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          if (!BUF_READY) begin
            state_q <= ST_IDLE;
          end else if (flush_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            flush_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!BUF_READY) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          done_q   <= 1'b0;
          vld_p0_q <= 1'b0;
        end
      endcase
    end
  end

  col_minmax_reducer u_reducer (
    .clk_i          (CLK_64MHZ),
    .rst_i          (red_rst),
    .sample_i       (RAM_DATA),
    .sample_valid_i (vld_p1_q),
    .dec_i          (dec_q),
    .min_o          (COL_MIN),
    .max_o          (COL_MAX),
    .strobe_o       (col_we)
  );

endmodule

// File: tb/tb_adc_buffer_reader.sv
// Directed bench for adc_buffer_reader: frame timing, wrap, decimation, handshake,
// abort and mid-frame reset, against a synchronous RAM model.
module tb_adc_buffer_reader;

  localparam int LOGN = 2100;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_ready;
  logic [10:0] trig_addr;
  logic [9:0]  pretrig;
  logic [1:0]  decimate;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data;
  logic [9:0]  col_addr;
  logic [7:0]  col_min, col_max;
  logic        col_we, vga_done;

  adc_buffer_reader dut (
    .CLK_64MHZ      (clk),
    .MASTER_RST     (rst),
    .BUF_READY      (buf_ready),
    .TRIG_ADDR      (trig_addr),
    .PRETRIG        (pretrig),
    .DECIMATE       (decimate),
    .RAM_ADDR       (ram_addr),
    .RAM_DATA       (ram_data),
    .COL_ADDR       (col_addr),
    .COL_MIN        (col_min),
    .COL_MAX        (col_max),
    .COL_WE         (col_we),
    .VGA_WRITE_DONE (vga_done)
  );

  always #5 clk = ~clk;

  int ram_mode = 0;
  always @(posedge clk) ram_data <= (ram_mode == 0) ? ram_addr[7:0] : 8'h80;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  int t0 = 1 << 30;
  int exp_gap = 1;
  int we_cnt, done_rel, first_we_rel, last_we_rel, gap_bad, addr_bad;
  int addr_log [LOGN];
  int cmin [640];
  int cmax [640];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (rel >= 0 && rel < LOGN) addr_log[rel] = int'(ram_addr);
    if (col_we) begin
      if (int'(col_addr) != we_cnt) addr_bad++;
      if (col_addr < 10'd640) begin
        cmin[col_addr] = int'(col_min);
        cmax[col_addr] = int'(col_max);
      end
      if (last_we_rel >= 0 && (rel - last_we_rel) != exp_gap) gap_bad++;
      if (first_we_rel < 0) first_we_rel = rel;
      last_we_rel = rel;
      we_cnt++;
    end
    if (vga_done && done_rel < 0) done_rel = rel;
  end

  task automatic clear_mon(input int gap);
    exp_gap = gap;
    we_cnt = 0; done_rel = -1; first_we_rel = -1; last_we_rel = -1;
    gap_bad = 0; addr_bad = 0;
    for (int k = 0; k < LOGN; k++) addr_log[k] = -1;
    for (int k = 0; k < 640; k++) begin cmin[k] = -1; cmax[k] = -1; end
  endtask

  // Raises BUF_READY so that the following clock edge ends "cycle 0".
  task automatic start_frame(input logic [10:0] ta, input logic [9:0] pt,
                             input logic [1:0] dc, input int mode, input int gap);
    @(posedge clk);
    #1;
    trig_addr = ta; pretrig = pt; decimate = dc; ram_mode = mode;
    buf_ready = 1'b1;
    t0 = cyc;
    clear_mon(gap);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 4000 && done_rel < 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (done_rel < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic drop_ready();
    @(posedge clk);
    #1 buf_ready = 1'b0;
    @(negedge clk);
    chk("done_before_drop_seen", int'(vga_done), 1);
    @(negedge clk);
    chk("done_after_drop", int'(vga_done), 0);
    chk("we_after_drop", int'(col_we), 0);
  endtask

  int hold_bad;
  int const_bad;

  initial begin
    rst = 1'b1; buf_ready = 1'b0; trig_addr = '0; pretrig = '0; decimate = '0;
    clear_mon(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_col_addr", int'(col_addr), 0);
    chk("rst_col_min", int'(col_min), 0);
    chk("rst_col_max", int'(col_max), 0);
    chk("rst_col_we", int'(col_we), 0);
    chk("rst_done", int'(vga_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Start address wraps below zero
    start_frame(11'h010, 10'h020, 2'd1, 0, 1);
    wait_done("s1");
    chk("s1_addr_c1", addr_log[1], 'h7F0);
    chk("s1_addr_c17", addr_log[17], 'h000);
    chk("s1_addr_c640", addr_log[640], 'h26F);
    chk("s1_col0_min", cmin[0], 'hF0);
    chk("s1_col0_max", cmax[0], 'hF0);
    chk("s1_col16_min", cmin[16], 'h00);
    chk("s1_col639_max", cmax[639], 'h6F);
    chk("s1_we_cnt", we_cnt, 640);
    chk("s1_first_we", first_we_rel, 3);
    chk("s1_last_we", last_we_rel, 642);
    chk("s1_done_cyc", done_rel, 643);
    chk("s1_gap_bad", gap_bad, 0);
    chk("s1_col_order", addr_bad, 0);

    // Done flag held while the buffer stays frozen
    hold_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!vga_done || col_we) hold_bad++;
    end
    chk("s4_done_hold", hold_bad, 0);
    drop_ready();

    // Decimation by 2; input changes after the start must be ignored
    start_frame(11'h100, 10'h000, 2'd2, 0, 2);
    repeat (5) @(posedge clk);
    #1 decimate = 2'd3; trig_addr = 11'h000; pretrig = 10'h055;
    wait_done("s2");
    chk("s2_addr_c1", addr_log[1], 'h100);
    chk("s2_col0_min", cmin[0], 'h00);
    chk("s2_col0_max", cmax[0], 'h01);
    chk("s2_col5_min", cmin[5], 'h0A);
    chk("s2_col5_max", cmax[5], 'h0B);
    chk("s2_we_cnt", we_cnt, 640);
    chk("s2_gap_bad", gap_bad, 0);
    chk("s2_done_cyc", done_rel, 1283);
    drop_ready();

    // DECIMATE=0 behaves as 1
    start_frame(11'h010, 10'h020, 2'd0, 0, 1);
    wait_done("s3a");
    chk("s3a_addr_c640", addr_log[640], 'h26F);
    chk("s3a_col0_min", cmin[0], 'hF0);
    chk("s3a_we_cnt", we_cnt, 640);
    chk("s3a_done_cyc", done_rel, 643);
    drop_ready();

    // DECIMATE=3 over constant data, start at the top of the buffer
    start_frame(11'h7FF, 10'h000, 2'd3, 1, 3);
    wait_done("s3b");
    const_bad = 0;
    for (int k = 0; k < 640; k++)
      if (cmin[k] != 'h80 || cmax[k] != 'h80) const_bad++;
    chk("s3b_const_cols", const_bad, 0);
    chk("s3b_we_cnt", we_cnt, 640);
    chk("s3b_gap_bad", gap_bad, 0);
    chk("s3b_addr_last", addr_log[1920], 'h77E);
    chk("s3b_done_cyc", done_rel, 1923);
    drop_ready();

    // Abort by dropping BUF_READY during cycle 100
    start_frame(11'h000, 10'h000, 2'd1, 0, 1);
    repeat (100) @(posedge clk);
    #1 buf_ready = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    chk("s5_no_late_we", int'(last_we_rel <= 101), 1);
    chk("s5_we_started", int'(we_cnt >= 98), 1);
    chk("s5_no_done", done_rel, -1);

    // Reset for one cycle at cycle 300 of a running frame
    start_frame(11'h200, 10'h005, 2'd1, 0, 1);
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    t0 = cyc;
    clear_mon(1);
    @(negedge clk);
    chk("s6_rst_ram_addr", int'(ram_addr), 0);
    chk("s6_rst_col_addr", int'(col_addr), 0);
    chk("s6_rst_min_max", int'({col_min, col_max}), 0);
    chk("s6_rst_we", int'(col_we), 0);
    chk("s6_rst_done", int'(vga_done), 0);
    wait_done("s6");
    chk("s6_addr_c1", addr_log[1], 'h1FB);
    chk("s6_first_we", first_we_rel, 3);
    chk("s6_col0_min", cmin[0], 'hFB);
    chk("s6_col_order", addr_bad, 0);
    chk("s6_we_cnt", we_cnt, 640);
    chk("s6_done_cyc", done_rel, 643);
    drop_ready();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
